random_dram_model: RTL and testbench

RANDOM_DRAM_MODEL -- requirements
Module: random_dram_model

---
 rtl/random_dram_pkg.sv | 23 ++
 rtl/lane_lfsr16.sv | 25 ++
 rtl/random_dram_model.sv | 102 ++++++++++
 tb/tb_random_dram_model.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/random_dram_pkg.sv
// Shared constants, mode encoding and lane seed derivation for random_dram_model.
package random_dram_pkg;

  localparam int unsigned LANE_W      = 16;
  localparam logic [15:0] SEED_OFFSET = 16'hACE1;

  typedef enum logic [1:0] {
    MODE_RANDOM    = 2'd0,
    MODE_ADDR_ECHO = 2'd1,
    MODE_HOLD      = 2'd2,
    MODE_ZERO      = 2'd3
  } mode_e;

  // Per-lane seed; an all-zero seed would lock the LFSR, so it is forced to 1.
  function automatic logic [LANE_W-1:0] lane_seed(input logic [LANE_W-1:0] base,
                                                  input int unsigned       lane);
    logic [LANE_W-1:0] s;
    s = base ^ (SEED_OFFSET + LANE_W'(lane));
    if (s == '0) s = LANE_W'(1);
    return s;
  endfunction

endpackage

// File: rtl/lane_lfsr16.sv
// One 16-bit Fibonacci LFSR lane (taps 15,13,12,10); load wins over advance.
// Ports: clk, load (take seed), advance (one step), seed, state.
module lane_lfsr16
  import random_dram_pkg::*;
(
  input  logic              clk,
  input  logic              load,
  input  logic              advance,
  input  logic [LANE_W-1:0] seed,
  output logic [LANE_W-1:0] state
);

  logic feedback;

  assign feedback = state[15] ^ state[13] ^ state[12] ^ state[10];

  always_ff @(posedge clk) begin
    if (load) begin
      state <= seed;
    end else if (advance) begin
      state <= {state[14:0], feedback};
    end
  end

endmodule

// File: rtl/random_dram_model.sv
// Behavioural DRAM stand-in for NPU testing: returns LFSR, address-echo, held
// or zero data after a fixed read latency, and signs/counts incoming writes.
// Ports: clk, rst (sync, active high), mode, rd_en, dram_addr,
//        dram_write_enable, wr_data, seed_load, seed_value,
//        rd_data, rd_valid, wr_checksum, wr_count.
module random_dram_model
  import random_dram_pkg::*;
#(
  parameter int unsigned NUM_LANES    = 4,
  parameter int unsigned AWIDTH       = 10,
  parameter int unsigned READ_LATENCY = 2,
  parameter logic [15:0] SEED         = 16'h0000,
  localparam int unsigned DWIDTH      = LANE_W * NUM_LANES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] dram_addr,
  input  logic              dram_write_enable,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              seed_load,
  input  logic [15:0]       seed_value,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_valid,
  output logic [DWIDTH-1:0] wr_checksum,
  output logic [15:0]       wr_count
);

  mode_e                               mode_sel;
  logic                                lfsr_load;
  logic                                lfsr_advance;
  logic [LANE_W-1:0]                   seed_base;
  logic [NUM_LANES-1:0][LANE_W-1:0]    lane_state;
  logic [DWIDTH-1:0]                   launch_data;
  logic [READ_LATENCY-1:0]             pipe_valid;
  logic [DWIDTH-1:0]                   pipe_data [READ_LATENCY];

  assign mode_sel = mode_e'(mode);

  // Reset reseeds from SEED; seed_load reseeds from seed_value.
  assign seed_base    = rst ? SEED : seed_value;
  assign lfsr_load    = rst | seed_load;
  assign lfsr_advance = rd_en & (mode_sel == MODE_RANDOM);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_lfsr16 u_lfsr (
      .clk     (clk),
      .load    (lfsr_load),
      .advance (lfsr_advance),
      .seed    (lane_seed(seed_base, i)),
      .state   (lane_state[i])
    );
  end

  // Word launched this cycle; lane_state is read before any load/advance.
  always_comb begin
    launch_data = '0;
    case (mode_sel)
      MODE_RANDOM, MODE_HOLD: launch_data = lane_state;
      MODE_ADDR_ECHO: begin
        for (int i = 0; i < NUM_LANES; i++) begin
          launch_data[i*LANE_W +: LANE_W] = LANE_W'(dram_addr);
        end
      end
      default: launch_data = '0;
    endcase
  end

  // Read latency pipeline; data stages only load on valid, so the final stage
  // keeps the last returned word during idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        pipe_data[k] <= '0;
      end
    end else begin
      pipe_valid[0] <= rd_en;
      if (rd_en) pipe_data[0] <= launch_data;
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipe_valid[k] <= pipe_valid[k-1];
        if (pipe_valid[k-1]) pipe_data[k] <= pipe_data[k-1];
      end
    end
  end

  assign rd_valid = pipe_valid[READ_LATENCY-1];
  assign rd_data  = pipe_data[READ_LATENCY-1];

  // Write signature (rotate-left then xor) and saturating write count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_checksum <= '0;
      wr_count    <= '0;
    end else if (dram_write_enable) begin
      wr_checksum <= {wr_checksum[DWIDTH-2:0], wr_checksum[DWIDTH-1]} ^ wr_data;
      if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_random_dram_model.sv
// Scoreboard bench for random_dram_model: driver pushes expected read words
// from a reference model, monitor pops and compares on each rd_valid.
module tb_random_dram_model;

  localparam int unsigned NL     = 4;
  localparam int unsigned AW     = 10;
  localparam int unsigned RL     = 2;
  localparam int unsigned DW     = 16 * NL;
  localparam logic [15:0] SEED_P = 16'h0000;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic          rd_en;
  logic [AW-1:0] dram_addr;
  logic          dram_write_enable;
  logic [DW-1:0] wr_data;
  logic          seed_load;
  logic [15:0]   seed_value;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [DW-1:0] wr_checksum;
  logic [15:0]   wr_count;

  random_dram_model #(
    .NUM_LANES    (NL),
    .AWIDTH       (AW),
    .READ_LATENCY (RL),
    .SEED         (SEED_P)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .mode              (mode),
    .rd_en             (rd_en),
    .dram_addr         (dram_addr),
    .dram_write_enable (dram_write_enable),
    .wr_data           (wr_data),
    .seed_load         (seed_load),
    .seed_value        (seed_value),
    .rd_data           (rd_data),
    .rd_valid          (rd_valid),
    .wr_checksum       (wr_checksum),
    .wr_count          (wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    longint        due;
  } exp_t;

  exp_t          sb[$];
  int            total = 0;
  int            bad   = 0;
  longint        edge_n = 0;
  logic [15:0]   m_lfsr [NL];
  logic [DW-1:0] m_chk;
  int            m_cnt;
  logic [DW-1:0] m_hold;
  logic          dir_en = 1'b0;
  logic [DW-1:0] dir_exp;

  function automatic void check(input string name, input logic [DW-1:0] act,
                                input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endfunction

  function automatic logic [15:0] m_seed(input logic [15:0] base, input int lane);
    logic [15:0] v;
    v = base ^ (16'hACE1 + 16'(lane));
    return (v == 16'h0000) ? 16'h0001 : v;
  endfunction

  function automatic logic [15:0] m_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // One cycle of stimulus, applied at the falling edge, plus the model's view
  // of what the following rising edge will do.
  task automatic step(input logic r, input logic [1:0] md, input logic re,
                      input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                      input logic sl, input logic [15:0] sv);
    logic [DW-1:0] word;
    exp_t e;
    @(negedge clk);
    rst = r; mode = md; rd_en = re; dram_addr = a;
    dram_write_enable = w; wr_data = wd; seed_load = sl; seed_value = sv;
    if (r) begin
      sb.delete();
      for (int i = 0; i < NL; i++) m_lfsr[i] = m_seed(SEED_P, i);
      m_chk = '0; m_cnt = 0; m_hold = '0;
    end else begin
      if (re) begin
        word = '0;
        for (int i = 0; i < NL; i++) begin
          case (md)
            2'd0, 2'd2: word[i*16 +: 16] = m_lfsr[i];
            2'd1:       word[i*16 +: 16] = 16'(a);
            default:    word[i*16 +: 16] = 16'h0000;
          endcase
        end
        e.data = dir_en ? dir_exp : word;
        e.due  = edge_n + RL;
        sb.push_back(e);
      end
      if (sl) begin
        for (int i = 0; i < NL; i++) m_lfsr[i] = m_seed(sv, i);
      end else if (re && md == 2'd0) begin
        for (int i = 0; i < NL; i++) m_lfsr[i] = m_next(m_lfsr[i]);
      end
      if (w) begin
        m_chk = {m_chk[DW-2:0], m_chk[DW-1]} ^ wd;
        if (m_cnt < 65535) m_cnt++;
      end
    end
    dir_en = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic rd(input logic [1:0] md, input logic [AW-1:0] a);
    step(1'b0, md, 1'b1, a, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic expect_next(input logic [DW-1:0] v);
    dir_en  = 1'b1;
    dir_exp = v;
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  initial begin
    exp_t e;
    logic exp_v;
    forever begin
      @(posedge clk);
      edge_n++;
      #1;
      exp_v = (sb.size() > 0) && (sb[0].due == edge_n);
      check("rd_valid", DW'(rd_valid), DW'(exp_v));
      if (exp_v) begin
        e = sb.pop_front();
        check("rd_data", rd_data, e.data);
        m_hold = e.data;
      end else begin
        check("rd_data_hold", rd_data, m_hold);
      end
      check("wr_checksum", wr_checksum, m_chk);
      check("wr_count", DW'(wr_count), DW'(m_cnt));
    end
  end

  initial begin
    rst = 1'b1; mode = 2'd0; rd_en = 1'b0; dram_addr = '0;
    dram_write_enable = 1'b0; wr_data = '0; seed_load = 1'b0; seed_value = '0;
    for (int i = 0; i < NL; i++) m_lfsr[i] = m_seed(SEED_P, i);
    m_chk = '0; m_cnt = 0; m_hold = '0;

    step(1'b1, 2'd0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    step(1'b1, 2'd0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    idle();
    check("reset_rd_data", rd_data, '0);
    check("reset_rd_valid", DW'(rd_valid), '0);
    check("reset_wr_checksum", wr_checksum, '0);
    check("reset_wr_count", DW'(wr_count), '0);

    // Directed reads with hand-derived words.
    expect_next(64'hACE4_ACE3_ACE2_ACE1); rd(2'd0, '0);
    expect_next(64'h59C9_59C7_59C5_59C3); rd(2'd0, '0);
    expect_next(64'hB393_B38F_B38B_B387); rd(2'd2, '0);
    expect_next(64'hB393_B38F_B38B_B387); rd(2'd2, '0);
    expect_next(64'h02A5_02A5_02A5_02A5); rd(2'd1, 10'h2A5);
    expect_next(64'h0);                   rd(2'd3, 10'h3FF);
    expect_next(64'hB393_B38F_B38B_B387); rd(2'd0, '0);
    idle();
    step(1'b0, 2'd0, 1'b0, '0, 1'b0, '0, 1'b1, 16'hACE1);
    expect_next(64'h0005_0002_0003_0001); rd(2'd0, '0);
    // Coincident seed_load and read returns the pre-load state.
    step(1'b0, 2'd0, 1'b1, '0, 1'b0, '0, 1'b1, 16'h1234);
    rd(2'd0, '0);
    repeat (4) idle();

    // Write signature from reset.
    step(1'b1, 2'd0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    step(1'b0, 2'd0, 1'b0, '0, 1'b1, 64'h1, 1'b0, '0);
    step(1'b0, 2'd0, 1'b0, '0, 1'b1, 64'h1, 1'b0, '0);
    idle();
    check("two_writes_checksum", wr_checksum, 64'h3);
    check("two_writes_count", DW'(wr_count), 64'd2);

    // Reset one cycle after a read: the pending word must vanish.
    rd(2'd0, '0);
    step(1'b1, 2'd0, 1'b1, '0, 1'b0, '0, 1'b0, '0);
    repeat (RL + 3) idle();
    check("reset_flush_empty", DW'(sb.size()), '0);

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      step(($urandom_range(49, 0) == 0), 2'($urandom_range(3, 0)), 1'($urandom),
           AW'($urandom), 1'($urandom), {$urandom, $urandom},
           ($urandom_range(19, 0) == 0), 16'($urandom));
    end
    repeat (RL + 2) idle();

    // Saturation of the write counter.
    step(1'b1, 2'd0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    for (int n = 0; n < 70000; n++) begin
      step(1'b0, 2'd0, ($urandom_range(7, 0) == 0), '0, 1'b1, {$urandom, $urandom},
           1'b0, '0);
    end
    idle();
    check("wr_count_saturated", DW'(wr_count), 64'hFFFF);

    repeat (RL + 3) idle();
    check("scoreboard_drained", DW'(sb.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
